// File: rtl/conv_acc_sched.sv
// rtl/conv_acc_sched.sv - per-pixel channel accumulation, bias/ReLU/round/saturate, output handshake
module conv_acc_sched #(
   parameter int PSUM_W = 21,
   parameter int ACC_W  = 26,
   parameter int BIAS_W = 16,
   parameter int OUT_W  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [4:0]          cfg_num_ch,
   input  logic [15:0]         cfg_num_pix,
   input  logic [BIAS_W-1:0]   cfg_bias,
   input  logic [4:0]          cfg_shift,
   input  logic                cfg_relu,
   input  logic [PSUM_W-1:0]   psum_in,
   input  logic                psum_valid,
   output logic                psum_ready,
   output logic [OUT_W-1:0]    out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {IDLE, ACC, POST, OUT} state_t;

   localparam logic signed [ACC_W+1:0] SAT_MAX = (ACC_W+2)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [ACC_W+1:0] SAT_MIN = ~SAT_MAX;

   state_t state, state_nx;

   logic signed [ACC_W-1:0]  acc;
   logic [4:0]               ch_cnt;
   logic [15:0]              pix_cnt;
   logic [4:0]               num_ch_m1;
   logic [15:0]              num_pix_m1;
   logic [BIAS_W-1:0]        bias_r;
   logic [4:0]               shift_r;
   logic                     relu_r;

   logic                     psum_hs;
   logic                     out_hs;
   logic                     last_ch;
   logic                     last_pix;

   logic signed [ACC_W:0]    t_sum;
   logic signed [ACC_W:0]    t_relu;
   logic signed [ACC_W+1:0]  rnd;
   logic signed [ACC_W+1:0]  t_rnd;
   logic signed [ACC_W+1:0]  r_shift;
   logic [OUT_W-1:0]         sat;

   assign psum_hs  = (state == ACC) && psum_valid;
   assign out_hs   = (state == OUT) && out_ready;
   assign last_ch  = (ch_cnt == num_ch_m1);
   assign last_pix = (pix_cnt == num_pix_m1);

   // Post-processing; the two extra bits keep bias and rounding offset from overflowing.
   always_comb begin
      t_sum   = {acc[ACC_W-1], acc} + {{(ACC_W+1-BIAS_W){bias_r[BIAS_W-1]}}, bias_r};
      t_relu  = (relu_r && t_sum[ACC_W]) ? '0 : t_sum;
      rnd     = (shift_r == 5'd0) ? '0 : ((ACC_W+2)'(1) << (shift_r - 5'd1));
      t_rnd   = {t_relu[ACC_W], t_relu} + rnd;
      r_shift = t_rnd >>> shift_r;
      if (r_shift > SAT_MAX)
         sat = SAT_MAX[OUT_W-1:0];
      else if (r_shift < SAT_MIN)
         sat = SAT_MIN[OUT_W-1:0];
      else
         sat = r_shift[OUT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = ACC;
         ACC:  if (psum_hs && last_ch) state_nx = POST;
         POST: state_nx = OUT;
         OUT:  if (out_hs) state_nx = last_pix ? IDLE : ACC;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      psum_ready = (state == ACC);
      out_valid  = (state == OUT);
      busy       = (state != IDLE);
      done       = out_hs && last_pix;
   end

   // Config is captured only at job start so mid-job changes cannot disturb a pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         ch_cnt     <= '0;
         pix_cnt    <= '0;
         num_ch_m1  <= '0;
         num_pix_m1 <= '0;
         bias_r     <= '0;
         shift_r    <= '0;
         relu_r     <= 1'b0;
         out_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  num_ch_m1  <= (cfg_num_ch == 5'd0) ? 5'd0 : cfg_num_ch - 5'd1;
                  num_pix_m1 <= (cfg_num_pix == 16'd0) ? 16'd0 : cfg_num_pix - 16'd1;
                  bias_r     <= cfg_bias;
                  shift_r    <= cfg_shift;
                  relu_r     <= cfg_relu;
                  acc        <= '0;
                  ch_cnt     <= '0;
                  pix_cnt    <= '0;
               end
            end
            ACC: begin
               if (psum_hs) begin
                  acc    <= acc + {{(ACC_W-PSUM_W){psum_in[PSUM_W-1]}}, psum_in};
                  ch_cnt <= last_ch ? 5'd0 : ch_cnt + 5'd1;
               end
            end
            POST: out_data <= sat;
            OUT: begin
               if (out_hs) begin
                  pix_cnt <= pix_cnt + 16'd1;
                  if (!last_pix)
                     acc <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_acc_sched.sv
// tb/tb_conv_acc_sched.sv - directed self-checking bench for conv_acc_sched
module tb_conv_acc_sched;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic [4:0]         cfg_num_ch;
   logic [15:0]        cfg_num_pix;
   logic [15:0]        cfg_bias;
   logic [4:0]         cfg_shift;
   logic               cfg_relu;
   logic [20:0]        psum_in;
   logic               psum_valid;
   logic               psum_ready;
   logic [7:0]         out_data;
   logic               out_valid;
   logic               out_ready;
   logic               busy;
   logic               done;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   conv_acc_sched dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_num_ch(cfg_num_ch), .cfg_num_pix(cfg_num_pix), .cfg_bias(cfg_bias),
      .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
      .psum_in(psum_in), .psum_valid(psum_valid), .psum_ready(psum_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done) done_cnt++;

   task automatic do_start(input logic [4:0] ch, input logic [15:0] pix,
                           input logic [15:0] b, input logic [4:0] sh, input logic rl);
      cfg_num_ch = ch; cfg_num_pix = pix; cfg_bias = b; cfg_shift = sh; cfg_relu = rl;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_psum(input logic [20:0] v, output bit ok);
      int n = 0;
      ok = 1'b0;
      psum_in = v;
      psum_valid = 1'b1;
      while (n < 50 && !ok) begin
         if (psum_ready) ok = 1'b1;
         @(negedge clk);
         n++;
      end
      psum_valid = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      int n = 0;
      ok = 1'b0;
      while (n < 50 && !ok) begin
         if (out_valid) ok = 1'b1;
         else @(negedge clk);
         n++;
      end
   endtask

   task automatic get_out(output logic [7:0] d, output bit ok, output bit dn);
      wait_valid(ok);
      d = out_data;
      dn = 1'b0;
      if (ok) begin
         out_ready = 1'b1;
         #1 dn = done;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      n_checks++;
      if ({psum_ready, out_valid, busy, done} !== 4'b0000 || out_data !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: ready/valid/busy/done=%b data=%0d required 0000/0",
                  {psum_ready, out_valid, busy, done}, out_data);
      end
   endtask

   task automatic test_basic;
      bit ok, dn;
      logic [7:0] d;
      bit all_ok = 1'b1;
      done_cnt = 0;
      do_start(5'd9, 16'd1, 16'd0, 5'd0, 1'b0);
      n_checks++;
      if (busy !== 1'b1 || psum_ready !== 1'b1) begin
         n_fail++; $display("FAIL basic_acc_entry: busy=%b ready=%b required 1/1", busy, psum_ready);
      end
      for (int i = 0; i < 9; i++) begin
         send_psum(21'sd10, ok);
         all_ok &= ok;
      end
      n_checks++;
      if (!all_ok) begin n_fail++; $display("FAIL basic_psum_timeout: accepted=0 required 1"); end
      n_checks++;
      if (out_valid !== 1'b0 || psum_ready !== 1'b0) begin
         n_fail++; $display("FAIL basic_post_cycle: valid=%b ready=%b required 0/0", out_valid, psum_ready);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || $signed(out_data) !== 8'sd90) begin
         n_fail++; $display("FAIL basic_latency: valid=%b data=%0d required 1/90", out_valid, $signed(out_data));
      end
      get_out(d, ok, dn);
      n_checks++;
      if (!ok || dn !== 1'b1) begin n_fail++; $display("FAIL basic_done: got=%b done=%b required 1/1", ok, dn); end
      n_checks++;
      if (busy !== 1'b0 || done_cnt != 1) begin
         n_fail++; $display("FAIL basic_idle: busy=%b done_cnt=%0d required 0/1", busy, done_cnt);
      end
   endtask

   task automatic test_sat_relu;
      logic [20:0] pv [3] = '{21'sd1000000, -21'sd1000000, -21'sd1000000};
      logic        rl [3] = '{1'b0, 1'b0, 1'b1};
      logic [7:0]  ex [3] = '{8'sd127, -8'sd128, 8'sd0};
      bit ok0, ok1, ok, dn;
      logic [7:0] d;
      for (int k = 0; k < 3; k++) begin
         do_start(5'd2, 16'd1, 16'd0, 5'd4, rl[k]);
         send_psum(pv[k], ok0);
         send_psum(pv[k], ok1);
         get_out(d, ok, dn);
         n_checks++;
         if (!(ok0 && ok1 && ok) || d !== ex[k] || dn !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_relu_%0d: data=%0d done=%b required %0d/1", k, $signed(d), dn, $signed(ex[k]));
         end
      end
   endtask

   task automatic test_rounding;
      bit ok0, ok, dn;
      logic [7:0] d;
      do_start(5'd1, 16'd1, 16'd3, 5'd3, 1'b0);
      send_psum(21'sd21, ok0);
      get_out(d, ok, dn);
      n_checks++;
      if (!(ok0 && ok) || d !== 8'sd3) begin
         n_fail++; $display("FAIL round_pos: data=%0d required 3", $signed(d));
      end
      do_start(5'd1, 16'd1, 16'd0, 5'd2, 1'b0);
      send_psum(-21'sd13, ok0);
      get_out(d, ok, dn);
      n_checks++;
      if (!(ok0 && ok) || d !== -8'sd3) begin
         n_fail++; $display("FAIL round_neg: data=%0d required -3", $signed(d));
      end
   endtask

   task automatic test_backpressure;
      logic [20:0] pv [12] = '{21'sd3, -21'sd7, 21'sd100, 21'sd20,
                               -21'sd50, -21'sd60, -21'sd70, -21'sd80,
                               21'sd200, 21'sd50, 21'sd1, 21'sd0};
      int          gap [12] = '{0, 2, 0, 1, 3, 0, 1, 0, 0, 2, 1, 0};
      logic [7:0]  ex [3] = '{8'sd61, -8'sd127, 8'sd127};
      bit ok, dn, all_ok;
      bit stall_bad;
      logic [7:0] d;
      done_cnt = 0;
      do_start(5'd4, 16'd3, 16'd5, 5'd1, 1'b0);
      for (int p = 0; p < 3; p++) begin
         all_ok = 1'b1;
         for (int c = 0; c < 4; c++) begin
            repeat (gap[p*4+c]) @(negedge clk);
            send_psum(pv[p*4+c], ok);
            all_ok &= ok;
         end
         if (p == 0) begin
            wait_valid(ok);
            all_ok &= ok;
            stall_bad = 1'b0;
            psum_in = 21'sd999;
            psum_valid = 1'b1;
            for (int s = 0; s < 5; s++) begin
               if (out_valid !== 1'b1 || psum_ready !== 1'b0 || $signed(out_data) !== 8'sd61)
                  stall_bad = 1'b1;
               @(negedge clk);
            end
            psum_valid = 1'b0;
            n_checks++;
            if (stall_bad) begin
               n_fail++;
               $display("FAIL bp_stall: valid=%b ready=%b data=%0d required 1/0/61",
                        out_valid, psum_ready, $signed(out_data));
            end
         end
         get_out(d, ok, dn);
         all_ok &= ok;
         n_checks++;
         if (!all_ok || d !== ex[p] || dn !== (p == 2)) begin
            n_fail++;
            $display("FAIL bp_pixel_%0d: data=%0d done=%b required %0d/%0d", p, $signed(d), dn,
                     $signed(ex[p]), (p == 2));
         end
      end
      n_checks++;
      if (done_cnt != 1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL bp_done_count: done_cnt=%0d busy=%b required 1/0", done_cnt, busy);
      end
   endtask

   task automatic test_cfg_edge;
      bit ok0, ok, dn;
      logic [7:0] d;
      do_start(5'd0, 16'd0, 16'd0, 5'd0, 1'b0);
      send_psum(21'sd37, ok0);
      get_out(d, ok, dn);
      n_checks++;
      if (!(ok0 && ok) || d !== 8'sd37 || dn !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL cfg_zero: data=%0d done=%b busy=%b required 37/1/0", $signed(d), dn, busy);
      end
   endtask

   task automatic test_start_while_busy;
      bit ok0, ok1, ok, dn;
      logic [7:0] d;
      do_start(5'd2, 16'd1, 16'd0, 5'd0, 1'b0);
      send_psum(21'sd5, ok0);
      do_start(5'd1, 16'd4, 16'd100, 5'd2, 1'b1);
      send_psum(-21'sd20, ok1);
      get_out(d, ok, dn);
      n_checks++;
      if (!(ok0 && ok1 && ok) || d !== -8'sd15 || dn !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_busy: data=%0d done=%b busy=%b required -15/1/0", $signed(d), dn, busy);
      end
   endtask

   task automatic test_async_reset;
      bit ok, dn, all_ok = 1'b1;
      logic [7:0] d;
      do_start(5'd9, 16'd1, 16'd0, 5'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         send_psum(21'sd7, ok);
         all_ok &= ok;
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({psum_ready, out_valid, busy, done} !== 4'b0000 || out_data !== 8'd0) begin
         n_fail++;
         $display("FAIL async_reset: ready/valid/busy/done=%b data=%0d required 0000/0",
                  {psum_ready, out_valid, busy, done}, out_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_start(5'd9, 16'd1, 16'd0, 5'd0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         send_psum(21'sd1, ok);
         all_ok &= ok;
      end
      get_out(d, ok, dn);
      n_checks++;
      if (!(all_ok && ok) || d !== 8'sd9 || dn !== 1'b1) begin
         n_fail++; $display("FAIL async_new_job: data=%0d done=%b required 9/1", $signed(d), dn);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0;
      cfg_num_ch = '0; cfg_num_pix = '0; cfg_bias = '0; cfg_shift = '0; cfg_relu = 1'b0;
      psum_in = '0; psum_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      @(negedge clk);
      test_basic;
      test_sat_relu;
      test_rounding;
      test_backpressure;
      test_cfg_edge;
      test_start_while_busy;
      test_async_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_acc_sched.md
Name: conv_acc_sched

Overview:
- Sequences the 9-way 21-bit partial-sum adder of the 3x3 convolution datapath across input channels and output pixels.
- Consumes one adder result per channel over a valid/ready handshake and accumulates NUM_CH results per output pixel.
- Applies bias, optional ReLU, a rounding right-shift and int8 saturation, then presents the pixel downstream with backpressure.
- Sits between the sum stage and the output writer; also reports busy/done to the top-level controller.

Parameters:
- PSUM_W, 21: width of the signed partial sum from the adder.
- ACC_W, 26: accumulator width (PSUM_W + 5; holds 16 channels plus bias without overflow).
- BIAS_W, 16: width of the signed bias.
- OUT_W, 8: width of the signed saturated output.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- cfg_num_ch  in  5  channels per pixel, range 1..16; 0 is treated as 1.
- cfg_num_pix  in  16  pixels per job; 0 is treated as 1.
- cfg_bias  in  BIAS_W  signed bias added once per pixel.
- cfg_shift  in  5  right-shift amount, 0..24.
- cfg_relu  in  1  clamp negative pre-shift values to 0.
- psum_in  in  PSUM_W  signed partial sum from the adder.
- psum_valid  in  1  psum_in is valid.
- psum_ready  out  1  block accepts psum_in.
- out_data  out  OUT_W  signed result pixel.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last pixel of the job is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - Accumulator, channel counter and pixel counter clear to 0.
  - psum_ready, out_valid, busy and done are 0; out_data is 0.
  - Reset mid-job discards all state; no partial output is produced.
- FSM states: IDLE, ACC, POST, OUT.
- IDLE:
  - start=1 latches all cfg_* inputs into internal registers.
  - Accumulator and both counters clear; next state is ACC.
  - cfg_* changes outside IDLE have no effect.
- ACC:
  - psum_ready=1.
  - On each handshake (psum_valid & psum_ready): acc += sign-extended psum_in, and ch_cnt increments.
  - If the handshake is for channel num_ch-1, the next state is POST and ch_cnt clears.
  - No handshake means the state holds.
- POST (exactly 1 cycle, psum_ready=0):
  - t = acc + sign-extended bias (ACC_W+1 bits).
  - If relu and t<0, then t=0.
  - If shift>0, r = (t + 2^(shift-1)) >>> shift (round half up); otherwise r = t.
  - Saturate r to [-128, 127] and register the result into out_data.
  - Next state is OUT.
- OUT:
  - out_valid=1; out_data is held stable until out_ready=1.
  - On handshake, pix_cnt increments.
  - If this was pixel num_pix-1: done=1 for one cycle and next state is IDLE.
  - Otherwise the accumulator clears and next state is ACC.
  - out_valid deasserts the cycle after the handshake.
- Latency:
  - Last-channel handshake at cycle N gives out_valid=1 at cycle N+2.
  - Minimum pixel period is num_ch+2 cycles (the channel handshakes, plus 1 POST cycle and 1 OUT cycle).
- Overlap: psum_ready is 0 in POST and OUT; psum_in is not accepted while a pixel is pending.
- start is ignored while busy=1.
- done and a new start in the same cycle cannot conflict, because start is sampled only in IDLE.
- Accumulator: no overflow is possible within the parameter ranges; no wrap handling is required.

Test Plan:
- Basic pixel:
  - Stimulus: num_ch=9, num_pix=1, bias=0, shift=0, relu=0; feed psum=+10 nine times.
  - Response: out_data=90 at 2 cycles after the last handshake, then done pulse and return to IDLE.
- Saturation and ReLU:
  - Stimulus: num_ch=2, psum=+1000000 twice, shift=4.
  - Response: out_data=127.
  - Stimulus: the same with psum=-1000000, relu=0.
  - Response: out_data=-128.
  - Stimulus: psum=-1000000, relu=1.
  - Response: out_data=0.
- Rounding with bias:
  - Stimulus: num_ch=1, psum=21, bias=3, shift=3.
  - Response: (24+4)>>>3 = 3.
  - Stimulus: psum=-13, bias=0, shift=2.
  - Response: (-13+2)>>>2 = -3.
- Backpressure and multi-pixel:
  - Stimulus: num_pix=3, num_ch=4; hold out_ready=0 for 5 cycles on pixel 0; random psum_valid gaps.
  - Response: out_data stable and psum_ready=0 while stalled; 3 outputs match the golden model; exactly one done pulse after the 3rd acceptance.
- Config edge cases:
  - Stimulus: num_ch=0 and num_pix=0.
  - Response: behaves as 1/1.
  - Stimulus: start pulsed while busy with changed cfg.
  - Response: ignored; the current job completes with the original config.
- Async reset mid-job:
  - Stimulus: drop rst_n in ACC after 5 of 9 channels; release; start a new job with psum=1 ×9.
  - Response: all outputs 0 during reset; the new job yields out_data=9 with no leftover accumulation.
